// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: captures one screen width of DDS samples per video frame
// into a double-buffered sample store, so the renderer always reads a complete trace.
// Frequency and waveform selection are snapshotted at capture start. Key presses
// therefore cannot tear a displayed frame.
module wave_capture_ctrl #(
   parameter int N_SAMPLES = 800,
   parameter int PHASE_W   = 16,
   parameter int ROM_LAT   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               hold,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic               wave_sel,
   output logic [7:0]         rom_addr,
   input  logic [7:0]         sine_q,
   input  logic [7:0]         square_q,
   input  logic [9:0]         rd_addr,
   output logic [7:0]         rd_data,
   output logic               front_valid,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);

   localparam int CNT_W = 10;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, SWAP} state_t;

   state_t              state_q, state_d;
   logic [PHASE_W-1:0]  fw;
   logic [PHASE_W-1:0]  phase;
   logic                ws;
   logic [CNT_W-1:0]    count;
   logic                start;
   logic                fill_last;
   logic                drain_last;
   logic                front;
   logic [ROM_LAT-1:0]  vld_p;
   logic [CNT_W-1:0]    idx_p [ROM_LAT];
   logic [7:0]          wr_data;
   logic                rd_in_range;
   logic [7:0]          bank0 [N_SAMPLES];
   logic [7:0]          bank1 [N_SAMPLES];

   assign start       = frame_start && !hold;
   assign fill_last   = (count == CNT_W'(N_SAMPLES - 1));
   assign drain_last  = (count == CNT_W'(ROM_LAT - 1));
   assign wr_data     = ws ? square_q : sine_q;
   assign rd_in_range = (32'(rd_addr) < N_SAMPLES);

   // Next-state logic with Moore outputs busy and frame_done
   always_comb begin
      state_d    = state_q;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = FILL;
         end
         FILL:    if (fill_last) state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = SWAP;
         SWAP: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture sequencing: phase walk, ROM addressing, sample/drain counter, bank swap, overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         phase       <= '0;
         rom_addr    <= '0;
         front       <= 1'b0;
         front_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (frame_start && state_q != IDLE) overrun <= 1'b1;
         case (state_q)
            IDLE: begin
               if (start) begin
                  phase <= '0;
                  count <= '0;
               end
            end
            FILL: begin
               rom_addr <= phase[PHASE_W-1 -: 8];
               phase    <= phase + fw;
               // The counter is reused to time the drain, so it restarts here
               count    <= fill_last ? '0 : count + 1'b1;
            end
            DRAIN: count <= count + 1'b1;
            SWAP: begin
               front       <= ~front;
               front_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Capture settings are pure data and are held for the whole capture
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start) begin
         fw <= freq_word;
         ws <= wave_sel;
      end
   end

   // Stage p0 carries the issued address. Later stages track ROM latency until write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= (state_q == FILL);
         for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Write-index pipeline mirroring the valid pipeline
   always_ff @(posedge clk) begin
      idx_p[0] <= count;
      for (int i = 1; i < ROM_LAT; i++) idx_p[i] <= idx_p[i-1];
   end

   // Back-bank write: whichever bank is not currently being displayed
   always_ff @(posedge clk) begin
      if (vld_p[ROM_LAT-1]) begin
         if (front) bank0[idx_p[ROM_LAT-1]] <= wr_data;
         else       bank1[idx_p[ROM_LAT-1]] <= wr_data;
      end
   end

   // Front-bank read. Unwritten RAM is masked until the first swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             rd_data <= '0;
      else if (!front_valid || !rd_in_range)  rd_data <= '0;
      else                                    rd_data <= front ? bank1[rd_addr] : bank0[rd_addr];
   end

endmodule
